uart_rx: RTL and testbench

- UART receiver; the receive-side counterpart of the team's uart_tx, running on the same 3.125 MHz clock.
- Deserialises 11-bit frames: start(0), 8 data bits MSB first, parity, stop(1).
- Checks parity (even or odd) and the stop bit.
- Presents the received byte with a one-cycle completion strobe to downstream logic.

---
 rtl/uart_rx.sv | 168 ++++++++++++++++
 tb/tb_uart_rx.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx.sv
// uart_rx: UART receiver for 11-bit frames (start, 8 data bits MSB first,
// parity, stop) on the 3.125 MHz system clock. Each bit is sampled once at
// its mid-bit clock index. The byte, the received parity bit and the error
// flags are presented together with a one-cycle rx_complete strobe.
`timescale 1ns/1ps
module uart_rx #(
  parameter int CLKS_PER_BIT = 27,
  parameter int SAMPLE_POINT = 13
) (
  input  logic       clk_3125,
  input  logic       rst,
  input  logic       rx,
  input  logic       parity_type,
  output logic [7:0] rx_msg,
  output logic       rx_parity,
  output logic       rx_parity_err,
  output logic       rx_frame_err,
  output logic       rx_complete
);

  localparam int CW = $clog2(CLKS_PER_BIT);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
    S_PARITY = 3'd3,
    S_STOP   = 3'd4
  } state_t;

  state_t        r_state;
  logic [CW-1:0] r_clk_cnt;
  logic [2:0]    r_bit_cnt;
  logic [7:0]    r_shift;
  logic          r_ptype;
  logic          r_par_bit;

  logic [7:0]    r_rx_msg;
  logic          r_rx_parity;
  logic          r_rx_parity_err;
  logic          r_rx_frame_err;
  logic          r_rx_complete;

  logic          w_sample;
  logic          w_bit_end;

  // Expected parity bit: even parity is the XOR of the data, odd is its complement.
  function automatic logic exp_parity(input logic [7:0] data, input logic odd);
    logic p;
    p = ^data;
    if (odd) begin
      exp_parity = ~p;
    end else begin
      exp_parity = p;
    end
  endfunction

  // Position within the current bit: mid-bit sample point and last clock of the bit.
  always_comb begin
    w_sample  = (r_clk_cnt == CW'(SAMPLE_POINT));
    w_bit_end = (r_clk_cnt == CW'(CLKS_PER_BIT - 1));
  end

  // Receive FSM: start detection, bit timing, sampling, checking and output registers.
  always_ff @(posedge clk_3125) begin
    if (rst) begin
      r_state         <= S_IDLE;
      r_clk_cnt       <= '0;
      r_bit_cnt       <= 3'd0;
      r_shift         <= 8'h00;
      r_ptype         <= 1'b0;
      r_par_bit       <= 1'b0;
      r_rx_msg        <= 8'h00;
      r_rx_parity     <= 1'b0;
      r_rx_parity_err <= 1'b0;
      r_rx_frame_err  <= 1'b0;
      r_rx_complete   <= 1'b0;
    end else begin
      r_rx_complete <= 1'b0;
      case (r_state)
        S_IDLE: begin
          r_bit_cnt <= 3'd0;
          if (!rx) begin
            // The detecting edge is clock index 0 of the start bit, so the
            // next edge already sees index 1.
            r_state   <= S_START;
            r_clk_cnt <= CW'(1);
            r_ptype   <= parity_type;
          end else begin
            r_clk_cnt <= '0;
          end
        end
        S_START: begin
          if (w_sample && rx) begin
            // Line went back high before mid-bit: glitch, not a frame.
            r_state   <= S_IDLE;
            r_clk_cnt <= '0;
          end else if (w_bit_end) begin
            r_state   <= S_DATA;
            r_clk_cnt <= '0;
            r_bit_cnt <= 3'd0;
          end else begin
            r_clk_cnt <= r_clk_cnt + CW'(1);
          end
        end
        S_DATA: begin
          if (w_sample) begin
            r_shift <= {r_shift[6:0], rx};
          end else begin
            r_shift <= r_shift;
          end
          if (w_bit_end) begin
            r_clk_cnt <= '0;
            if (r_bit_cnt == 3'd7) begin
              r_state <= S_PARITY;
            end else begin
              r_bit_cnt <= r_bit_cnt + 3'd1;
            end
          end else begin
            r_clk_cnt <= r_clk_cnt + CW'(1);
          end
        end
        S_PARITY: begin
          if (w_sample) begin
            r_par_bit <= rx;
          end else begin
            r_par_bit <= r_par_bit;
          end
          if (w_bit_end) begin
            r_state   <= S_STOP;
            r_clk_cnt <= '0;
          end else begin
            r_clk_cnt <= r_clk_cnt + CW'(1);
          end
        end
        S_STOP: begin
          if (w_sample) begin
            // Finish at mid-stop so a following start is never missed.
            r_rx_msg        <= r_shift;
            r_rx_parity     <= r_par_bit;
            r_rx_parity_err <= (r_par_bit != exp_parity(r_shift, r_ptype));
            r_rx_frame_err  <= ~rx;
            r_rx_complete   <= 1'b1;
            r_state         <= S_IDLE;
            r_clk_cnt       <= '0;
          end else begin
            r_clk_cnt <= r_clk_cnt + CW'(1);
          end
        end
        default: begin
          r_state   <= S_IDLE;
          r_clk_cnt <= '0;
          r_bit_cnt <= 3'd0;
        end
      endcase
    end
  end

  // Outputs come straight from their registers.
  always_comb begin
    rx_msg        = r_rx_msg;
    rx_parity     = r_rx_parity;
    rx_parity_err = r_rx_parity_err;
    rx_frame_err  = r_rx_frame_err;
    rx_complete   = r_rx_complete;
  end

endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: self-checking bench for uart_rx. Directed frames come from a
// vector table, corner cases are hand-written sequences, and random frames
// are checked against a parity/framing model built from counting ones.
`timescale 1ns/1ps
module tb_uart_rx;

  logic       clk_3125 = 1'b0;
  logic       rst = 1'b1;
  logic       rx = 1'b1;
  logic       parity_type = 1'b0;
  logic [7:0] rx_msg;
  logic       rx_parity;
  logic       rx_parity_err;
  logic       rx_frame_err;
  logic       rx_complete;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  typedef struct {
    int         cyc;
    logic [7:0] msg;
    logic       par;
    logic       perr;
    logic       ferr;
  } obs_t;

  typedef struct {
    logic [7:0] d;
    logic       pt;
    logic       pbit;
    logic       stop;
    logic [7:0] e_msg;
    logic       e_par;
    logic       e_perr;
    logic       e_ferr;
    int         gap;
  } vec_t;

  obs_t obs_q[$];
  vec_t vecs[8];

  uart_rx #(.CLKS_PER_BIT(27), .SAMPLE_POINT(13)) dut (
    .clk_3125      (clk_3125),
    .rst           (rst),
    .rx            (rx),
    .parity_type   (parity_type),
    .rx_msg        (rx_msg),
    .rx_parity     (rx_parity),
    .rx_parity_err (rx_parity_err),
    .rx_frame_err  (rx_frame_err),
    .rx_complete   (rx_complete)
  );

  // 3.125 MHz clock (320 ns period).
  always #160 clk_3125 = ~clk_3125;

  // Cycle index: after the Nth rising edge cyc == N.
  always @(posedge clk_3125) cyc <= cyc + 1;

  // Record every completion cycle with the outputs presented alongside it.
  always @(negedge clk_3125) begin
    if (rx_complete === 1'b1) begin
      obs_q.push_back('{cyc, rx_msg, rx_parity, rx_parity_err, rx_frame_err});
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk_3125);
      #1;
    end
  endtask

  // Reference model: parity error when the total count of ones (data plus
  // parity bit) has the wrong oddness for the selected parity.
  function automatic obs_t model(input logic [7:0] d, input logic pt, input logic pbit,
                                 input logic stop, input int tp);
    int ones;
    obs_t o;
    ones = 0;
    for (int i = 0; i < 8; i++) ones += int'(d[i]);
    o.cyc  = tp;
    o.msg  = d;
    o.par  = pbit;
    o.perr = (((ones + int'(pbit)) % 2) != int'(pt));
    o.ferr = !stop;
    return o;
  endfunction

  // Drive one frame, 27 clocks per bit, starting right after the current edge.
  // Returns the cycle at which the completion strobe must be seen.
  task automatic send_frame(input logic [7:0] d, input logic pt, input logic pbit,
                            input logic stop, input bit glitch, output int t_pulse);
    logic [10:0] bits;
    bits        = {1'b0, d, pbit, stop};
    parity_type = pt;
    t_pulse     = cyc + 284;
    for (int k = 0; k < 11; k++) begin
      rx = bits[10-k];
      if (glitch && k > 0) begin
        tick(2);
        rx = ~bits[10-k];
        tick(1);
        rx = bits[10-k];
        tick(24);
      end else begin
        tick(27);
      end
      if (k == 0) parity_type = 1'($urandom);
    end
    rx = 1'b1;
  endtask

  task automatic expect_frame(input string tag, input int t_pulse, input logic [7:0] m,
                              input logic p, input logic pe, input logic fe);
    obs_t o;
    check({tag, " pulse count"}, obs_q.size(), 1);
    if (obs_q.size() > 0) begin
      o = obs_q.pop_front();
      check({tag, " pulse cycle"}, o.cyc, t_pulse);
      check({tag, " rx_msg"}, o.msg, m);
      check({tag, " rx_parity"}, o.par, p);
      check({tag, " parity_err"}, o.perr, pe);
      check({tag, " frame_err"}, o.ferr, fe);
    end
    obs_q.delete();
  endtask

  task automatic check_outputs_zero(input string tag);
    check({tag, " rx_msg"}, rx_msg, 8'h00);
    check({tag, " rx_parity"}, rx_parity, 1'b0);
    check({tag, " parity_err"}, rx_parity_err, 1'b0);
    check({tag, " frame_err"}, rx_frame_err, 1'b0);
    check({tag, " complete"}, rx_complete, 1'b0);
  endtask

  // Guard against a stuck run.
  initial begin
    #20_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int         tp;
    obs_t       m;
    logic [7:0] d;
    logic       pt;
    logic       pb;
    logic       st;
    logic [10:0] bits;

    vecs[0] = '{8'h41, 1'b0, 1'b0, 1'b1, 8'h41, 1'b0, 1'b0, 1'b0, 20};
    vecs[1] = '{8'h41, 1'b1, 1'b1, 1'b1, 8'h41, 1'b1, 1'b0, 1'b0, 20};
    vecs[2] = '{8'h41, 1'b1, 1'b0, 1'b1, 8'h41, 1'b0, 1'b1, 1'b0, 20};
    vecs[3] = '{8'hA5, 1'b0, 1'b0, 1'b0, 8'hA5, 1'b0, 1'b0, 1'b1, 30};
    vecs[4] = '{8'h55, 1'b0, 1'b0, 1'b1, 8'h55, 1'b0, 1'b0, 1'b0, 0};
    vecs[5] = '{8'hAA, 1'b0, 1'b0, 1'b1, 8'hAA, 1'b0, 1'b0, 1'b0, 0};
    vecs[6] = '{8'hFF, 1'b0, 1'b0, 1'b1, 8'hFF, 1'b0, 1'b0, 1'b0, 0};
    vecs[7] = '{8'h00, 1'b0, 1'b0, 1'b1, 8'h00, 1'b0, 1'b0, 1'b0, 20};

    // Reset, then a long idle line.
    rst = 1'b1;
    tick(3);
    rst = 1'b0;
    check_outputs_zero("reset");
    tick(100);
    check("idle no pulse", obs_q.size(), 0);
    check_outputs_zero("idle");

    // Directed table; entries 4..7 run back-to-back at the 297-clock spacing.
    for (int i = 0; i < 8; i++) begin
      send_frame(vecs[i].d, vecs[i].pt, vecs[i].pbit, vecs[i].stop, 1'b0, tp);
      expect_frame($sformatf("vec%0d", i), tp, vecs[i].e_msg, vecs[i].e_par,
                   vecs[i].e_perr, vecs[i].e_ferr);
      if (vecs[i].gap > 0) begin
        tick(vecs[i].gap);
        check($sformatf("vec%0d no stray pulse", i), obs_q.size(), 0);
      end
    end

    // False start: short low pulse, then a valid frame.
    rx = 1'b0;
    tick(5);
    rx = 1'b1;
    tick(40);
    check("false start no pulse", obs_q.size(), 0);
    check("false start msg held", rx_msg, 8'h00);
    send_frame(8'h3C, 1'b0, 1'b0, 1'b1, 1'b0, tp);
    expect_frame("after false start", tp, 8'h3C, 1'b0, 1'b0, 1'b0);

    // Reset during data bit 4 of a frame aborts it; the next frame is clean.
    bits = {1'b0, 8'h99, 1'b0, 1'b1};
    for (int k = 0; k < 4; k++) begin
      rx = bits[10-k];
      tick(27);
    end
    rx = bits[6];
    tick(10);
    rst = 1'b1;
    rx  = 1'b1;
    tick(3);
    rst = 1'b0;
    check_outputs_zero("mid-frame reset");
    tick(320);
    check("mid-frame reset no pulse", obs_q.size(), 0);
    send_frame(8'h7E, 1'b0, 1'b0, 1'b1, 1'b0, tp);
    expect_frame("after reset", tp, 8'h7E, 1'b0, 1'b0, 1'b0);

    // Random frames with glitches between sample points and random spacing.
    for (int i = 0; i < 20; i++) begin
      d  = 8'($urandom);
      pt = 1'($urandom);
      pb = 1'($urandom);
      st = ($urandom_range(0, 3) != 0);
      send_frame(d, pt, pb, st, 1'b1, tp);
      m = model(d, pt, pb, st, tp);
      expect_frame($sformatf("rand%0d", i), m.cyc, m.msg, m.par, m.perr, m.ferr);
      if (st) begin
        tick($urandom_range(0, 15));
      end else begin
        tick($urandom_range(1, 15));
      end
    end
    tick(30);
    check("final no stray pulse", obs_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
